// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
//
// Serial-to-parallel front end for the 16-bit datapath. A word is shifted in
// MSB first from `sin`, one bit per rising edge on which `sen` is high. Once
// all 16 bits are in, the word is held with `valid` high until the downstream
// register stage acknowledges it with `ack`.
//
// Optional feature macro: SERIAL_WORD_LOADER_PARITY_EN
//   defined   : a 17th strobed bit carries even parity over the 16 data bits;
//               `error` flags a parity mismatch on the held word.
//   undefined : 16 bits per word, `error` is constant 0.
//
// Ports:
//   clk    in   1   system clock, all state changes on the rising edge
//   reset  in   1   asynchronous, active-high reset
//   start  in   1   request to begin capturing a new word
//   sin    in   1   serial data bit
//   sen    in   1   bit strobe, `sin` sampled only when high
//   ack    in   1   downstream has consumed `word`
//   word   out  16  assembled word, stable whenever `valid` is high
//   valid  out  1   `word` is complete and held
//   busy   out  1   a capture is in progress
//   error  out  1   parity mismatch on the held word (0 without the macro)
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module serial_word_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sin,
    input  logic        sen,
    input  logic        ack,
    output logic [15:0] word,
    output logic        valid,
    output logic        busy,
    output logic        error
);

    // The parity state is only part of the machine when the feature is built.
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd3
    } state_t;
`endif

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    // Even parity over a 16-bit word: 1 when the word holds an odd number of 1s.
    function automatic logic even_parity16(input logic [15:0] data);
        even_parity16 = ^data;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] word_q,  word_d;
    logic        valid_q, valid_d;
    logic        busy_q,  busy_d;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    logic        error_q, error_d;
`endif

    // Next-state and next-output computation for the capture machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;
        busy_d  = busy_q;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        error_d = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // The held word is left untouched until a new capture shifts it.
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (sen) begin
                    word_d = {word_q[14:0], sin};
                    // 4-bit counter wraps 15 -> 0 on the 16th bit.
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                        // Stay busy: the parity bit is still to come.
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end

`ifdef SERIAL_WORD_LOADER_PARITY_EN
            ST_PARITY: begin
                if (sen) begin
                    // Data plus parity bit must hold an even number of 1s.
                    error_d = even_parity16(word_q) ^ sin;
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif

            ST_DONE: begin
                // Word is frozen; serial inputs are ignored until acknowledged.
                if (ack) begin
                    valid_d = 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                    error_d = 1'b0;
`endif
                    if (start) begin
                        // Back-to-back turnaround: first bit may arrive next edge.
                        state_d = ST_SHIFT;
                        cnt_d   = 4'd0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle state.
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                error_d = 1'b0;
`endif
            end
        endcase
    end

    // State and output registers; reset aborts any capture and drops the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            word_q  <= 16'h0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            error_q <= error_d;
`endif
        end
    end

    assign word  = word_q;
    assign valid = valid_q;
    assign busy  = busy_q;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
